// File: rtl/div_unit_pkg.sv
// div_unit_pkg: state encoding, control constants and operand helpers for the divider
package div_unit_pkg;
  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;
  localparam logic [31:0] ZERO_WORD           = 32'h0000_0000;
  localparam logic        DIV_RESULT_READY    = 1'b1;
  localparam logic        DIV_RESULT_NOT_READY = 1'b0;
  localparam logic        DIV_START           = 1'b1;
  localparam logic        DIV_STOP            = 1'b0;
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? -v : v;
  endfunction
endpackage

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring 32-bit divider for DIV/DIVU with registered result
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);
  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        sign1_q, sign1_d, sign2_q, sign2_d, signed_q, signed_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;
  logic [32:0] diff;
  // work_q[63:32] is the remainder with the next dividend bit already shifted in
  assign diff = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    signed_d  = signed_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == ZERO_WORD) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d   = DIV_ON;
            cnt_d     = '0;
            work_d    = {ZERO_WORD, cond_neg(opdata1_i, signed_div_i && opdata1_i[31]), 1'b0};
            divisor_d = cond_neg(opdata2_i, signed_div_i && opdata2_i[31]);
            sign1_d   = opdata1_i[31];
            sign2_d   = opdata2_i[31];
            signed_d  = signed_div_i;
          end
        end else begin
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end
      end
      DIV_BYZERO: begin
        state_d  = DIV_END;
        result_d = '0;
        ready_d  = DIV_RESULT_READY;
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d   = DIV_FREE;
          cnt_d     = '0;
          work_d    = '0;
          divisor_d = '0;
        end else if (!cnt_q[5]) begin
          work_d = diff[32] ? {work_q[63:0], 1'b0} : {diff[31:0], work_q[31:0], 1'b1};
          cnt_d  = cnt_q + 6'd1;
        end else begin
          state_d  = DIV_END;
          result_d = {cond_neg(work_q[64:33], signed_q && sign1_q),
                      cond_neg(work_q[31:0], signed_q && (sign1_q ^ sign2_q))};
          ready_d  = DIV_RESULT_READY;
        end
      end
      default: begin
        if (start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      signed_q  <= 1'b0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      signed_q  <= signed_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end
  assign result_o = result_q;
  assign ready_o  = ready_q;
endmodule
